// File: rtl/sram_input_loader.sv
// sram_input_loader: streams a 28x28 8-bit image into the input SRAM as saturated Q-format words,
// then lends the SRAM address port to the downstream reader until it releases the frame.
module sram_input_loader #(
    parameter int DEPTH = 784,
    parameter int ZP    = 0,
    parameter int SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_sram_we,
    output logic [15:0] o_sram_d,
    output logic [9:0]  o_sram_addr,
    input  logic [9:0]  i_rd_addr,
    input  logic        i_release,
    output logic        o_load_done,
    output logic [7:0]  o_frame_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;
    localparam int VW = (SHIFT + 11 > 18) ? SHIFT + 11 : 18;
    localparam logic [9:0] LAST = 10'(DEPTH - 1);
    state_t         r_state;
    logic [9:0]     r_cnt;
    logic [9:0]     r_waddr;
    logic           r_we;
    logic [15:0]    r_d;
    logic           r_done;
    logic [7:0]     r_frame_cnt;
    logic signed [9:0]    w_diff;
    logic signed [VW-1:0] w_ext;
    logic signed [VW-1:0] w_val;
    logic                 w_pos_ovf;
    logic                 w_neg_ovf;
    logic [15:0]          w_d;
    always_comb begin
        w_diff    = $signed({2'b00, i_in_data}) - $signed(10'(ZP));
        w_ext     = {{(VW-10){w_diff[9]}}, w_diff};
        w_val     = w_ext <<< SHIFT;
        // anything whose bits above 15 are not a pure sign extension is out of int16 range
        w_pos_ovf = !w_val[VW-1] && |w_val[VW-2:15];
        w_neg_ovf = w_val[VW-1] && !(&w_val[VW-2:15]);
        w_d       = w_pos_ovf ? 16'h7fff : w_neg_ovf ? 16'h8000 : w_val[15:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_we        <= 1'b0;
            r_d         <= '0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_we <= 1'b0;
                    if (i_start) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                    end
                end
                LOAD: begin
                    r_we <= i_in_valid;
                    if (i_in_valid) begin
                        r_waddr <= r_cnt;
                        r_d     <= w_d;
                        if (r_cnt == LAST) r_state <= DRAIN;
                        else r_cnt <= r_cnt + 10'd1;
                    end
                end
                DRAIN: begin
                    r_we        <= 1'b0;
                    r_state     <= READY;
                    r_done      <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                READY: begin
                    r_we <= 1'b0;
                    if (i_release) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end
    assign o_in_ready  = (r_state == LOAD);
    assign o_sram_we   = r_we;
    assign o_sram_d    = r_d;
    assign o_sram_addr = (r_state == READY) ? i_rd_addr : r_waddr;
    assign o_load_done = r_done;
    assign o_frame_cnt = r_frame_cnt;
endmodule
